// File: rtl/rotate_rho_engine.sv
// Keccak rho step, one lane per cycle: one shared offset selector and one L-bit barrel rotator.
// Handshake: start is a level request that is sampled only in IDLE; Ready pulses for the single DONE cycle.
module rotate_rho_engine #(
    parameter int L    = 64,
    parameter int LOGL = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              inv,
    input  logic [25*L-1:0]   in_state,
    output logic [25*L-1:0]   out_state,
    output logic              Ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            inv_q;
    logic [4:0]      cnt_q;
    logic [L-1:0]    lane_q [25];
    logic [25*L-1:0] out_q;

    logic [4:0]      sel_idx;
    logic [L-1:0]    sel_lane;
    logic [LOGL-1:0] r;
    logic [LOGL-1:0] amt;
    logic [2*L-1:0]  dbl;
    logic [L-1:0]    rot_lane;

    function automatic int raw_offset(input logic [4:0] i);
        case (i)
            5'd0:    return 0;
            5'd1:    return 1;
            5'd2:    return 190;
            5'd3:    return 28;
            5'd4:    return 91;
            5'd5:    return 36;
            5'd6:    return 300;
            5'd7:    return 6;
            5'd8:    return 55;
            5'd9:    return 276;
            5'd10:   return 3;
            5'd11:   return 10;
            5'd12:   return 171;
            5'd13:   return 153;
            5'd14:   return 231;
            5'd15:   return 105;
            5'd16:   return 45;
            5'd17:   return 15;
            5'd18:   return 21;
            5'd19:   return 136;
            5'd20:   return 210;
            5'd21:   return 66;
            5'd22:   return 253;
            5'd23:   return 120;
            5'd24:   return 78;
            default: return 0;
        endcase
    endfunction

    // Counter value 25 is the extra ROT cycle that publishes the finished buffer.
    always_comb begin
        sel_idx  = (cnt_q < 5'd25) ? cnt_q : 5'd0;
        sel_lane = lane_q[sel_idx];
        r        = (LOGL)'(raw_offset(sel_idx));
        amt      = inv_q ? -r : r;
        dbl      = {sel_lane, sel_lane} << amt;
        rot_lane = dbl[2*L-1:L];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ROT;
            ROT:     if (cnt_q == 5'd25) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inv_q <= 1'b0;
            cnt_q <= 5'd0;
            out_q <= '0;
            for (int i = 0; i < 25; i++) lane_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) inv_q <= inv;
                LOAD: begin
                    cnt_q <= 5'd0;
                    for (int z = 0; z < L; z++)
                        for (int i = 0; i < 25; i++)
                            lane_q[i][z] <= in_state[25*z+i];
                end
                ROT: begin
                    if (cnt_q == 5'd25) begin
                        for (int z = 0; z < L; z++)
                            for (int i = 0; i < 25; i++)
                                out_q[25*z+i] <= lane_q[i][z];
                    end else begin
                        lane_q[sel_idx] <= rot_lane;
                        cnt_q           <= cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_state = out_q;
    assign Ready     = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
